// File: rtl/four_to_one_rr_mux_pkg.sv
// four_to_one_pkg: shared channel count, channel-id type and output-register state encoding
package four_to_one_pkg;
    localparam int NUM_CH = 4;
    typedef logic [1:0] ch_id_t;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/four_to_one_rr_mux_if.sv
// four_to_one_rr_mux_if: four-channel input handshake, registered output handshake and beat counter
interface four_to_one_rr_mux_if #(parameter int WIDTH = 8, parameter int CNT_W = 16);
    logic [3:0]         in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_ready;
    logic [CNT_W-1:0]   beat_cnt;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sel, beat_cnt);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sel, beat_cnt);
endinterface

// File: rtl/four_to_one_rr_mux_arb.sv
// rr_arbiter_4: round-robin grant starting after the last transferred channel
module rr_arbiter_4
    import four_to_one_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output ch_id_t            grant_id
);
    ch_id_t last_grant;
    logic   found;
    always_comb begin
        found = 1'b0;
        grant_id = last_grant;
        for (int k = 1; k <= NUM_CH; k++)
            if (!found && req[last_grant + 2'(k)]) begin
                found = 1'b1;
                grant_id = last_grant + 2'(k);
            end
        grant = found ? 4'b0001 << grant_id : '0;
    end
    // the pointer only moves when the granted beat is actually taken
    always_ff @(posedge clk)
        if (rst) last_grant <= 2'd3;
        else if (advance) last_grant <= grant_id;
endmodule

// File: rtl/four_to_one_rr_mux.sv
// four_to_one_rr_mux: round-robin 4:1 mux into a single full-throughput output register
module four_to_one_rr_mux
    import four_to_one_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    four_to_one_rr_mux_if.slave bus
);
    state_t           state, state_nxt;
    logic             can_load, xfer;
    logic [3:0]       grant, rdy;
    ch_id_t           gid;
    logic [CNT_W-1:0] cnt;
    rr_arbiter_4 arb (.clk(clk), .rst(rst), .req(bus.in_valid), .advance(xfer), .grant(grant), .grant_id(gid));
    always_comb begin
        can_load = state == EMPTY || bus.out_ready;
        rdy = (can_load && !rst) ? grant : '0;
        xfer = |(bus.in_valid & rdy);
        state_nxt = xfer ? FULL : (bus.out_ready ? EMPTY : state);
    end
    always_ff @(posedge clk)
        state <= rst ? EMPTY : state_nxt;
    always_ff @(posedge clk)
        if (rst) begin
            bus.out_data <= '0;
            bus.out_sel <= '0;
            cnt <= '0;
        end else if (xfer) begin
            bus.out_data <= bus.in_data[gid*WIDTH +: WIDTH];
            bus.out_sel <= gid;
            cnt <= cnt + 1'b1;
        end
    assign bus.in_ready = rdy;
    assign bus.out_valid = state == FULL;
    assign bus.beat_cnt = cnt;
endmodule

// File: tb/tb_four_to_one_rr_mux.sv
// tb_four_to_one_rr_mux: table vectors plus scoreboard of accepted beats against a round-robin model
module tb_four_to_one_rr_mux;
    typedef struct {logic [3:0] v; logic ordy; logic [3:0] rdy;} vec_t;
    typedef struct {logic [7:0] d; logic [1:0] s;} beat_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    beat_t q[$];
    logic [1:0] m_lg;
    logic [3:0] m_cnt;
    vec_t tab[12];
    four_to_one_rr_mux_if #(.WIDTH(8), .CNT_W(4)) bus ();
    four_to_one_rr_mux #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [3:0] model_rdy(input logic [3:0] v, input logic ordy);
        logic [1:0] c;
        if (q.size() != 0 && !ordy) return 4'b0;
        for (int k = 1; k <= 4; k++) begin
            c = m_lg + 2'(k);
            if (v[c]) return 4'b0001 << c;
        end
        return 4'b0;
    endfunction
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 4'hf;
        bus.out_ready = 1'b1;
        bus.in_data = $urandom;
        #1 chk("rst_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_sel", 32'(bus.out_sel), 0);
        chk("rst_beat_cnt", 32'(bus.beat_cnt), 0);
        rst = 1'b0;
        bus.in_valid = 4'h0;
        q.delete();
        m_lg = 2'd3;
        m_cnt = 4'd0;
    endtask
    task automatic step(input logic [3:0] v, input logic ordy, input logic [3:0] tab_rdy, input bit use_tab, input string nm);
        logic [3:0] er;
        logic [31:0] d;
        beat_t b;
        @(negedge clk);
        d = $urandom;
        bus.in_valid = v;
        bus.in_data = d;
        bus.out_ready = ordy;
        er = use_tab ? tab_rdy : model_rdy(v, ordy);
        #1;
        chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'(er));
        chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
        chk({nm, "_beat_cnt"}, 32'(bus.beat_cnt), 32'(m_cnt));
        if (q.size() != 0 && ordy) begin
            b = q.pop_front();
            chk({nm, "_out_data"}, 32'(bus.out_data), 32'(b.d));
            chk({nm, "_out_sel"}, 32'(bus.out_sel), 32'(b.s));
        end
        if ((v & er) != 0)
            for (int c = 0; c < 4; c++)
                if (er[c]) begin
                    q.push_back('{d[c*8 +: 8], 2'(c)});
                    m_lg = 2'(c);
                    m_cnt = m_cnt + 4'd1;
                end
    endtask
    initial begin
        tab[0]  = '{4'b1111, 1'b1, 4'b0001};
        tab[1]  = '{4'b1111, 1'b1, 4'b0010};
        tab[2]  = '{4'b1010, 1'b1, 4'b1000};
        tab[3]  = '{4'b1010, 1'b1, 4'b0010};
        tab[4]  = '{4'b0100, 1'b0, 4'b0000};
        tab[5]  = '{4'b0100, 1'b1, 4'b0100};
        tab[6]  = '{4'b0000, 1'b1, 4'b0000};
        tab[7]  = '{4'b0000, 1'b0, 4'b0000};
        tab[8]  = '{4'b1001, 1'b0, 4'b1000};
        tab[9]  = '{4'b1001, 1'b0, 4'b0000};
        tab[10] = '{4'b0001, 1'b1, 4'b0001};
        tab[11] = '{4'b0000, 1'b1, 4'b0000};
        bus.in_valid = 4'h0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        do_reset();
        foreach (tab[i]) step(tab[i].v, tab[i].ordy, tab[i].rdy, 1'b1, $sformatf("tab%0d", i));
        do_reset();
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, 4'b0, 1'b0, $sformatf("rr%0d", i));
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 4'b0, 1'b0, $sformatf("stall%0d", i));
        step(4'b1111, 1'b1, 4'b0001, 1'b1, "resume");
        step(4'b0000, 1'b1, 4'b0, 1'b0, "drain");
        step(4'b0000, 1'b1, 4'b0, 1'b0, "empty");
        do_reset();
        for (int i = 0; i < 17; i++) step(4'b1111, 1'b1, 4'b0, 1'b0, $sformatf("wrap%0d", i));
        step(4'b0000, 1'b1, 4'b0, 1'b0, "wrap_drain");
        chk("wrap_cnt_is_1", 32'(bus.beat_cnt), 1);
        step(4'b1111, 1'b0, 4'b0, 1'b0, "fill");
        step(4'b1111, 1'b0, 4'b0, 1'b0, "hold");
        do_reset();
        step(4'b1111, 1'b1, 4'b0001, 1'b1, "post_rst");
        step(4'b0000, 1'b1, 4'b0, 1'b0, "post_drain");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
